// File: rtl/wrr_packet_arbiter.sv
// Packet-granular weighted round-robin arbiter.
// Merges C_S_NUM_QUEUES AXI-Stream queues into one master stream. A queue keeps
// the grant for up to weights[q] whole packets before service rotates to the
// next eligible queue. Packets are never interleaved, and each packet costs
// one IDLE decision cycle before its first beat. Per-queue packet counters are
// exported for register readout.
module wrr_packet_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_NUM_QUEUES       = 5,
    parameter int C_WEIGHT_WIDTH       = 8,
    parameter int C_QSEL_WIDTH         = 3
) (
    input  logic                                             axi_aclk,
    input  logic                                             sw_rst,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]                   m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                 m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]                  m_axis_tuser,
    output logic                                             m_axis_tvalid,
    input  logic                                             m_axis_tready,
    output logic                                             m_axis_tlast,

    input  logic [C_S_NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_grp,
    input  logic [C_S_NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_grp,
    input  logic [C_S_NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_grp,
    input  logic [C_S_NUM_QUEUES-1:0]                        s_axis_tvalid_grp,
    output logic [C_S_NUM_QUEUES-1:0]                        s_axis_tready_grp,
    input  logic [C_S_NUM_QUEUES-1:0]                        s_axis_tlast_grp,

    input  logic                                             enable,
    input  logic [C_S_NUM_QUEUES*C_WEIGHT_WIDTH-1:0]         weights_grp,
    output logic [C_S_NUM_QUEUES*32-1:0]                     pkt_cnt_grp
);

    localparam int N  = C_S_NUM_QUEUES;
    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;
    localparam int WW = C_WEIGHT_WIDTH;
    localparam int QW = C_QSEL_WIDTH;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [QW-1:0] grant_q;
    logic [QW-1:0] grant_next;
    logic [WW-1:0] credit;
    logic [WW-1:0] credit_next;
    logic          cnt_inc;

    logic [DW-1:0] q_data   [N];
    logic [SW-1:0] q_strb   [N];
    logic [UW-1:0] q_user   [N];
    logic [WW-1:0] q_weight [N];
    logic [31:0]   pkt_cnt  [N];
    logic [N-1:0]  eligible;

    logic          scan_found;
    logic [QW-1:0] scan_q;

    // Unpack the flat per-queue buses into arrays so the grant mux is a plain index.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign q_data[i]                = s_axis_tdata_grp[i*DW +: DW];
        assign q_strb[i]                = s_axis_tstrb_grp[i*SW +: SW];
        assign q_user[i]                = s_axis_tuser_grp[i*UW +: UW];
        assign q_weight[i]              = weights_grp[i*WW +: WW];
        assign eligible[i]              = s_axis_tvalid_grp[i] && (q_weight[i] != '0);
        assign pkt_cnt_grp[i*32 +: 32]  = pkt_cnt[i];
    end

    // Queue index grant_q+k folded back into 0..N-1 (k never exceeds N).
    function automatic logic [QW-1:0] wrap_idx(input logic [QW-1:0] g, input int k);
        int s;
        s = int'(g) + k;
        if (s >= N) begin
            s = s - N;
        end
        return QW'(s);
    endfunction

    // Round-robin scan starting just after the current grant; the current queue is tried last.
    always_comb begin
        scan_found = 1'b0;
        scan_q     = '0;
        for (int k = 1; k <= N; k++) begin
            if (!scan_found && eligible[wrap_idx(grant_q, k)]) begin
                scan_found = 1'b1;
                scan_q     = wrap_idx(grant_q, k);
            end
        end
    end

    // Next-state, credit bookkeeping and the combinational grant mux.
    always_comb begin
        state_next        = state;
        grant_next        = grant_q;
        credit_next       = credit;
        cnt_inc           = 1'b0;
        m_axis_tdata      = '0;
        m_axis_tstrb      = '0;
        m_axis_tuser      = '0;
        m_axis_tvalid     = 1'b0;
        m_axis_tlast      = 1'b0;
        s_axis_tready_grp = '0;

        case (state)
            IDLE: begin
                if (enable) begin
                    if (eligible[grant_q] && (credit != '0)) begin
                        state_next = IN_PKT;
                    end else if (scan_found) begin
                        grant_next  = scan_q;
                        credit_next = q_weight[scan_q];
                        state_next  = IN_PKT;
                    end
                end
            end

            IN_PKT: begin
                m_axis_tdata               = q_data[grant_q];
                m_axis_tstrb               = q_strb[grant_q];
                m_axis_tuser               = q_user[grant_q];
                m_axis_tlast               = s_axis_tlast_grp[grant_q];
                m_axis_tvalid              = s_axis_tvalid_grp[grant_q];
                s_axis_tready_grp[grant_q] = m_axis_tready;
                if (s_axis_tvalid_grp[grant_q] && m_axis_tready && s_axis_tlast_grp[grant_q]) begin
                    credit_next = (credit != '0) ? (credit - WW'(1)) : '0;
                    cnt_inc     = 1'b1;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, grant pointer and credit registers; reset parks the pointer on the last queue so the first scan starts at queue 0.
    always_ff @(posedge axi_aclk) begin
        if (sw_rst) begin
            state   <= IDLE;
            grant_q <= QW'(N - 1);
            credit  <= '0;
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            credit  <= credit_next;
        end
    end

    // Per-queue forwarded-packet counters, bumped on each accepted tlast beat (wrap at 2^32).
    always_ff @(posedge axi_aclk) begin
        if (sw_rst) begin
            for (int i = 0; i < N; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (cnt_inc) begin
            pkt_cnt[grant_q] <= pkt_cnt[grant_q] + 32'd1;
        end
    end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Self-checking bench for wrr_packet_arbiter: a table of grant-order vectors
// with hand-computed sequences, plus hand-written multi-cycle sequences for
// backpressure, enable drop and mid-packet reset.
module tb_wrr_packet_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int UW = 8;
    localparam int WW = 8;
    localparam int QW = 3;

    logic              clk = 1'b0;
    logic              sw_rst;
    logic [DW-1:0]     m_axis_tdata;
    logic [SW-1:0]     m_axis_tstrb;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [N*DW-1:0]   s_axis_tdata_grp;
    logic [N*SW-1:0]   s_axis_tstrb_grp;
    logic [N*UW-1:0]   s_axis_tuser_grp;
    logic [N-1:0]      s_axis_tvalid_grp;
    logic [N-1:0]      s_axis_tready_grp;
    logic [N-1:0]      s_axis_tlast_grp;
    logic              enable;
    logic [N*WW-1:0]   weights_grp;
    logic [N*32-1:0]   pkt_cnt_grp;

    wrr_packet_arbiter #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_NUM_QUEUES       (N),
        .C_WEIGHT_WIDTH       (WW),
        .C_QSEL_WIDTH         (QW)
    ) dut (
        .axi_aclk          (clk),
        .sw_rst            (sw_rst),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tstrb      (m_axis_tstrb),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .s_axis_tdata_grp  (s_axis_tdata_grp),
        .s_axis_tstrb_grp  (s_axis_tstrb_grp),
        .s_axis_tuser_grp  (s_axis_tuser_grp),
        .s_axis_tvalid_grp (s_axis_tvalid_grp),
        .s_axis_tready_grp (s_axis_tready_grp),
        .s_axis_tlast_grp  (s_axis_tlast_grp),
        .enable            (enable),
        .weights_grp       (weights_grp),
        .pkt_cnt_grp       (pkt_cnt_grp)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [N*WW-1:0] w;
        logic [N-1:0]    m;
        string           seq;
    } vec_t;

    vec_t          vecs [5];

    int            total = 0;
    int            passed = 0;
    int            cyc;
    int            samp_cyc;
    int            src_len  [N];
    int            src_beat [N];
    int            src_pkt  [N];
    logic [N-1:0]  src_mask;
    logic          got_beat;
    int            beat_q;
    int            beat_n;
    logic          beat_last;
    logic [N-1:0]  samp_ready;
    logic          samp_tvalid;

    function automatic logic [N*WW-1:0] mkw(input int w0, input int w1, input int w2,
                                            input int w3, input int w4);
        return {8'(w4), 8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endfunction

    function automatic logic [DW-1:0] src_data(input int q);
        return {8'(q), 8'(src_pkt[q]), 8'(src_beat[q]), 8'hA5};
    endfunction

    function automatic logic [31:0] cnt_of(input int q);
        return pkt_cnt_grp[q*32 +: 32];
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Present the current head beat of every source queue.
    task automatic apply_stimulus();
        for (int q = 0; q < N; q++) begin
            s_axis_tvalid_grp[q]         = src_mask[q];
            s_axis_tdata_grp[q*DW +: DW] = src_data(q);
            s_axis_tuser_grp[q*UW +: UW] = {4'(q), 4'(src_beat[q])};
            s_axis_tstrb_grp[q*SW +: SW] = 4'(q + 1);
            s_axis_tlast_grp[q]          = (src_beat[q] == src_len[q] - 1);
        end
    endtask

    task automatic reset_sources();
        for (int q = 0; q < N; q++) begin
            src_beat[q] = 0;
            src_pkt[q]  = 0;
        end
    endtask

    // One clock: sample at negedge, check any output beat, then advance sources after the edge.
    task automatic run_cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        samp_cyc    = cyc;
        samp_ready  = s_axis_tready_grp;
        samp_tvalid = m_axis_tvalid;
        hs          = s_axis_tvalid_grp & s_axis_tready_grp;
        got_beat    = m_axis_tvalid && m_axis_tready;
        if (got_beat) begin
            beat_q    = int'(m_axis_tdata[31:24]);
            beat_n    = int'(m_axis_tdata[15:8]);
            beat_last = m_axis_tlast;
            check_output("beat_queue_range", 64'(beat_q < N), 64'd1);
            if (beat_q < N) begin
                check_output("beat_tdata", 64'(m_axis_tdata), 64'(src_data(beat_q)));
                check_output("beat_tuser", 64'(m_axis_tuser), 64'({4'(beat_q), 4'(src_beat[beat_q])}));
                check_output("beat_tstrb", 64'(m_axis_tstrb), 64'(beat_q + 1));
                check_output("beat_tlast", 64'(m_axis_tlast),
                             64'(src_beat[beat_q] == src_len[beat_q] - 1));
                check_output("beat_ready_onehot", 64'(hs), 64'(N'(1) << beat_q));
            end
        end else begin
            check_output("no_stray_handshake", 64'(hs), 64'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int q = 0; q < N; q++) begin
            if (hs[q]) begin
                if (src_beat[q] == src_len[q] - 1) begin
                    src_beat[q] = 0;
                    src_pkt[q]++;
                end else begin
                    src_beat[q]++;
                end
            end
        end
        apply_stimulus();
    endtask

    task automatic do_reset();
        sw_rst   = 1'b1;
        src_mask = '0;
        reset_sources();
        apply_stimulus();
        @(posedge clk);
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
        cyc    = 0;
        check_output("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_output("reset_tlast", 64'(m_axis_tlast), 64'd0);
        check_output("reset_tready_grp", 64'(s_axis_tready_grp), 64'd0);
        check_output("reset_pkt_cnt", 64'(pkt_cnt_grp), 64'd0);
    endtask

    initial begin
        int k;
        int e;
        int n;
        int exp_cnt [N];
        int q2_seen;
        logic q0_after;
        logic ready0_bad;
        int seen;
        logic last_seen;
        logic idle_bad;
        logic resumed;
        int nb;
        logic first_ok;

        sw_rst        = 1'b1;
        enable        = 1'b0;
        m_axis_tready = 1'b0;
        weights_grp   = mkw(1, 1, 1, 1, 1);
        src_mask      = '0;
        for (int q = 0; q < N; q++) begin
            src_len[q] = 1;
        end
        reset_sources();
        apply_stimulus();

        // Grant-order vectors: weights, valid mask (bit q = queue q), expected grant queues.
        vecs[0].w = mkw(2, 1, 1, 1, 1); vecs[0].m = 5'b11111; vecs[0].seq = "001234001234";
        vecs[1].w = mkw(1, 0, 1, 1, 1); vecs[1].m = 5'b11111; vecs[1].seq = "023402340234";
        vecs[2].w = mkw(1, 1, 1, 3, 1); vecs[2].m = 5'b01000; vecs[2].seq = "3333333";
        vecs[3].w = mkw(3, 1, 0, 2, 1); vecs[3].m = 5'b10101; vecs[3].seq = "00040004";
        vecs[4].w = mkw(1, 2, 1, 1, 1); vecs[4].m = 5'b00110; vecs[4].seq = "112112";

        for (int v = 0; v < 5; v++) begin
            do_reset();
            weights_grp   = vecs[v].w;
            src_mask      = vecs[v].m;
            m_axis_tready = 1'b1;
            enable        = 1'b1;
            for (int q = 0; q < N; q++) begin
                src_len[q] = 1;
                exp_cnt[q] = 0;
            end
            apply_stimulus();
            n = vecs[v].seq.len();
            k = 0;
            for (int i = 0; i < 4 * n + 10 && k < n; i++) begin
                run_cycle();
                if (got_beat) begin
                    e = int'(vecs[v].seq[k]) - 48;
                    check_output($sformatf("v%0d_grant%0d", v, k), 64'(beat_q), 64'(e));
                    check_output($sformatf("v%0d_timing%0d", v, k), 64'(samp_cyc), 64'(2 * k + 1));
                    exp_cnt[e]++;
                    k++;
                end
            end
            check_output($sformatf("v%0d_grants_collected", v), 64'(k), 64'(n));
            for (int q = 0; q < N; q++) begin
                check_output($sformatf("v%0d_pkt_cnt%0d", v, q), 64'(cnt_of(q)), 64'(exp_cnt[q]));
            end
        end

        // q2 4-beat packet under toggling backpressure while q0 waits.
        do_reset();
        weights_grp   = mkw(1, 1, 1, 1, 1);
        src_mask      = 5'b00100;
        for (int q = 0; q < N; q++) begin
            src_len[q] = 1;
        end
        src_len[2]    = 4;
        m_axis_tready = 1'b0;
        enable        = 1'b1;
        apply_stimulus();
        q2_seen    = 0;
        q0_after   = 1'b0;
        ready0_bad = 1'b0;
        for (int i = 0; i < 40 && !q0_after; i++) begin
            m_axis_tready = ((i % 2) == 1);
            run_cycle();
            if (q2_seen < 4 && samp_ready[0]) begin
                ready0_bad = 1'b1;
            end
            if (got_beat) begin
                if (beat_q == 2) begin
                    check_output("bp_q2_beat_order", 64'(beat_n), 64'(q2_seen));
                    q2_seen++;
                end else if (beat_q == 0) begin
                    check_output("bp_q0_after_q2_last", 64'(q2_seen), 64'd4);
                    q0_after = 1'b1;
                end
            end
            if (i == 0) begin
                src_mask = 5'b00101;
                apply_stimulus();
            end
        end
        check_output("bp_q2_beats", 64'(q2_seen), 64'd4);
        check_output("bp_q0_granted", 64'(q0_after), 64'd1);
        check_output("bp_q0_ready_low", 64'(ready0_bad), 64'd0);

        // enable dropped on the 2nd beat of a 3-beat packet.
        do_reset();
        weights_grp   = mkw(1, 1, 1, 1, 1);
        src_mask      = 5'b00010;
        for (int q = 0; q < N; q++) begin
            src_len[q] = 3;
        end
        m_axis_tready = 1'b1;
        enable        = 1'b1;
        apply_stimulus();
        seen      = 0;
        last_seen = 1'b0;
        for (int i = 0; i < 20 && !last_seen; i++) begin
            run_cycle();
            if (got_beat) begin
                check_output("en_beat_order", 64'(beat_n), 64'(seen));
                seen++;
                if (seen == 1) begin
                    enable = 1'b0;
                end
                if (beat_last) begin
                    last_seen = 1'b1;
                end
            end
        end
        check_output("en_pkt_beats", 64'(seen), 64'd3);
        check_output("en_pkt_tlast", 64'(last_seen), 64'd1);
        idle_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            if (got_beat || samp_tvalid) begin
                idle_bad = 1'b1;
            end
        end
        check_output("en_held_idle", 64'(idle_bad), 64'd0);
        check_output("en_pkt_cnt1", 64'(cnt_of(1)), 64'd1);
        enable  = 1'b1;
        resumed = 1'b0;
        for (int i = 0; i < 4 && !resumed; i++) begin
            run_cycle();
            if (got_beat) begin
                resumed = 1'b1;
                check_output("en_resume_queue", 64'(beat_q), 64'd1);
                check_output("en_resume_beat", 64'(beat_n), 64'd0);
            end
        end
        check_output("en_resumed", 64'(resumed), 64'd1);

        // sw_rst pulsed in the middle of q1's packet.
        do_reset();
        weights_grp   = mkw(1, 1, 1, 1, 1);
        src_mask      = 5'b11111;
        for (int q = 0; q < N; q++) begin
            src_len[q] = 2;
        end
        m_axis_tready = 1'b1;
        enable        = 1'b1;
        apply_stimulus();
        nb = 0;
        for (int i = 0; i < 20 && nb < 3; i++) begin
            run_cycle();
            if (got_beat) begin
                nb++;
            end
        end
        check_output("rst_pre_beats", 64'(nb), 64'd3);
        check_output("rst_pre_cnt0", 64'(cnt_of(0)), 64'd1);
        sw_rst   = 1'b1;
        src_mask = '0;
        apply_stimulus();
        run_cycle();
        sw_rst   = 1'b0;
        reset_sources();
        src_mask = 5'b11111;
        apply_stimulus();
        check_output("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_output("rst_mid_pkt_cnt", 64'(pkt_cnt_grp), 64'd0);
        first_ok = 1'b0;
        for (int i = 0; i < 4 && !first_ok; i++) begin
            run_cycle();
            if (got_beat) begin
                first_ok = 1'b1;
                check_output("rst_first_grant", 64'(beat_q), 64'd0);
                check_output("rst_first_beat", 64'(beat_n), 64'd0);
            end
        end
        check_output("rst_regranted", 64'(first_ok), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wrr_packet_arbiter.md
Name: wrr_packet_arbiter

Overview:
- Packet-granular weighted round-robin arbiter that merges C_S_NUM_QUEUES AXI-Stream queues into one master stream.
- Sits between the per-queue packet sources (generator/RX queues) and the shared output path.
- Each queue may send up to a configurable number of packets per turn before service rotates.
- Keeps per-queue sent-packet counters for register readout.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, tdata width of both master and slave sides
C_M_AXIS_TUSER_WIDTH, 128, tuser width of both sides
C_S_NUM_QUEUES, 5, number of slave queues (2..16)
C_WEIGHT_WIDTH, 8, width of each per-queue weight
C_QSEL_WIDTH, 3, width of the queue index; must be >= ceil(log2(C_S_NUM_QUEUES))

Ports:
axi_aclk  in  1  clock
sw_rst  in  1  synchronous active-high reset
m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  data of granted queue
m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  strobes
m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  tuser
m_axis_tvalid  out  1  valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  end of packet
s_axis_tdata_grp  in  N*C_M_AXIS_DATA_WIDTH  packed queue data, queue i at slice i
s_axis_tstrb_grp  in  N*C_M_AXIS_DATA_WIDTH/8  packed strobes
s_axis_tuser_grp  in  N*C_M_AXIS_TUSER_WIDTH  packed tuser
s_axis_tvalid_grp  in  N  per-queue valid
s_axis_tready_grp  out  N  per-queue ready
s_axis_tlast_grp  in  N  per-queue last
enable  in  1  permits new grants
weights_grp  in  N*C_WEIGHT_WIDTH  packets per turn per queue; 0 disables the queue
pkt_cnt_grp  out  N*32  packets forwarded per queue

Behaviour:
- Interface: one clock, axi_aclk. Reset sw_rst is synchronous and active-high.
- Reset values:
  - state=IDLE, grant_q=N-1 (so the first scan starts at queue 0), credit=0.
  - All pkt_cnt=0.
  - m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready_grp=0.
  - Reset mid-packet abandons the packet; there is no recovery or flush.
- eligible(q) = s_axis_tvalid_grp[q] && weights[q]!=0.
- State IDLE (m_axis_tvalid=0, all s_axis_tready=0):
  - If enable=0: stay in IDLE.
  - Else if eligible(grant_q) && credit!=0: go to IN_PKT with grant_q unchanged.
  - Else scan q=grant_q+1 .. grant_q+N modulo N (grant_q itself is checked last) and take the first eligible queue:
    - grant_q<=q, credit<=weights[q], go to IN_PKT.
  - If no queue is eligible: stay in IDLE; grant_q and credit are unchanged.
  - Work-conserving: leftover credit of a non-valid current queue is forfeited.
- State IN_PKT:
  - m_axis_{tdata,tstrb,tuser,tlast} = slice grant_q of the slave buses (combinational mux).
  - m_axis_tvalid = s_axis_tvalid_grp[grant_q].
  - s_axis_tready_grp[grant_q] = m_axis_tready; all other readys are 0.
  - Beats are never dropped, reordered or interleaved with another queue.
  - On a handshake with tlast=1:
    - credit<=credit-1 (saturating at 0);
    - pkt_cnt[grant_q]++ (32-bit, wraps);
    - next state IDLE.
- Latency: the first beat is presentable in the cycle after the IDLE decision. Every packet is preceded by exactly one IDLE cycle, so back-to-back throughput loses one cycle per packet.
- Weights are sampled only on credit reload. A weight change mid-turn takes effect at the next reload. Weight set to 0 mid-turn makes the queue ineligible at the next IDLE decision.
- enable falling during IN_PKT: the current packet completes, then the block holds IDLE.
- Simultaneous tlast handshake and weight change: the count is updated; the new weight applies from the next decision.

Test Plan:
- Weights {2,1,1,1,1}, all queues backlogged with 1-beat packets, m_axis_tready=1 → grant order q0,q0,q1,q2,q3,q4,q0,q0,…; m_axis_tvalid high every other cycle.
- q2 sends a 4-beat packet while m_axis_tready toggles 1,0,1,0… and q0 is valid → all 4 q2 beats appear in order; s_axis_tready_grp[0]=0 throughout; q0 is granted only after q2's tlast.
- Weights {1,0,1,1,1}, all valid → q1 is never granted and s_axis_tready_grp[1] stays 0; pkt_cnt[1]=0 after 20 packets.
- Only q3 valid, weight 3, 7 packets → all 7 forwarded from q3 with credit reloading; pkt_cnt[3]=7.
- enable dropped on the 2nd beat of a 3-beat packet → packet completes with tlast; m_axis_tvalid then stays 0 while enable=0. Re-asserting enable resumes service.
- sw_rst pulsed mid-packet → next cycle m_axis_tvalid=0 and all pkt_cnt=0; with all queues valid, the first grant after reset is q0.
